// File: rtl/dec_lut_scheduler.sv
// Two-requester round-robin front end for a shared DEC_LUT decoder: latches the granted
// codeword, masks stale found during blanking, bounds the wait and returns N per request.
module dec_lut_scheduler #(
  parameter int unsigned W_BITS      = 34,
  parameter int unsigned N_BITS      = 21,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [W_BITS-1:0] req0_w,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [W_BITS-1:0] req1_w,
  output logic [W_BITS-1:0] dec_w,
  input  logic              dec_found,
  input  logic [N_BITS-1:0] dec_n,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [N_BITS-1:0] resp_n,
  output logic              resp_timeout,
  output logic              busy
);

  localparam int unsigned CntMax = (BLANK_CYC > TIMEOUT_CYC) ? BLANK_CYC : TIMEOUT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] BlankLast   = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  typedef enum logic [1:0] {StIdle, StBlank, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [W_BITS-1:0]   dec_w_q, dec_w_d;
  logic                id_q, id_d;
  logic                rr_q, rr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_BITS-1:0]   resp_n_q, resp_n_d;
  logic                resp_to_q, resp_to_d;

  logic grant_any;
  logic grant_id;

  // Pointer owner wins when valid; otherwise the other requester takes the slot.
  assign grant_any = (state_q == StIdle) && !rst && (req0_valid || req1_valid);
  assign grant_id  = rr_q ? req1_valid : !req0_valid;

  assign req0_ready   = grant_any && !grant_id;
  assign req1_ready   = grant_any && grant_id;
  assign dec_w        = dec_w_q;
  assign resp_valid   = (state_q == StResp);
  assign resp_id      = id_q;
  assign resp_n       = resp_n_q;
  assign resp_timeout = resp_to_q;
  assign busy         = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    dec_w_d   = dec_w_q;
    id_d      = id_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    resp_n_d  = resp_n_q;
    resp_to_d = resp_to_q;
    case (state_q)
      StIdle: begin
        if (grant_any) begin
          dec_w_d = grant_id ? req1_w : req0_w;
          id_d    = grant_id;
          rr_d    = !grant_id;
          cnt_d   = '0;
          state_d = StBlank;
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWait: begin
        // found takes precedence over an expiring timeout in the same cycle
        if (dec_found) begin
          resp_n_d  = dec_n;
          resp_to_d = 1'b0;
          state_d   = StResp;
        end else if (cnt_q == TimeoutLast) begin
          resp_n_d  = '0;
          resp_to_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dec_w_q   <= '0;
      id_q      <= 1'b0;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      resp_n_q  <= '0;
      resp_to_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dec_w_q   <= dec_w_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      resp_n_q  <= resp_n_d;
      resp_to_q <= resp_to_d;
    end
  end

endmodule

// File: tb/tb_dec_lut_scheduler.sv
// Directed bench for dec_lut_scheduler: grant order, blanking, timeout, backpressure, reset.
module tb_dec_lut_scheduler;

  localparam logic [33:0] W0 = 34'h2AAAAAAAA;
  localparam logic [33:0] W1 = 34'h155555555;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [33:0] req0_w;
  logic        req1_valid, req1_ready;
  logic [33:0] req1_w;
  logic [33:0] dec_w;
  logic        dec_found;
  logic [20:0] dec_n;
  logic        resp_valid, resp_ready, resp_id, resp_timeout, busy;
  logic [20:0] resp_n;

  int checks;
  int failures;

  dec_lut_scheduler #(
    .W_BITS     (34),
    .N_BITS     (21),
    .BLANK_CYC  (2),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_w      (req0_w),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_w      (req1_w),
    .dec_w       (dec_w),
    .dec_found   (dec_found),
    .dec_n       (dec_n),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_n      (resp_n),
    .resp_timeout(resp_timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dec_w"}, dec_w, 0);
    chk({tag, "_resp_id"}, resp_id, 0);
    chk({tag, "_resp_n"}, resp_n, 0);
    chk({tag, "_resp_timeout"}, resp_timeout, 0);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
  endtask

  // Entered in the grant cycle with the requester's valid already high; found at cycle 3.
  task automatic run_txn(input logic id, input logic [33:0] w, input logic [33:0] prev_w,
                         input logic [20:0] n, input logic last);
    #1;
    chk("txn_dec_w_hold", dec_w, prev_w);
    chk("txn_req0_ready", req0_ready, !id);
    chk("txn_req1_ready", req1_ready, id);
    tick();
    chk("txn_dec_w_new", dec_w, w);
    chk("txn_busy", busy, 1);
    tick();
    tick();
    dec_found = 1'b1;
    dec_n     = n;
    tick();
    dec_found = 1'b0;
    chk("txn_resp_valid", resp_valid, 1);
    chk("txn_resp_id", resp_id, id);
    chk("txn_resp_n", resp_n, n);
    chk("txn_resp_timeout", resp_timeout, 0);
    chk("txn_dec_w_stable", dec_w, w);
    resp_ready = 1'b1;
    if (last) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_w     = '0;
    req1_w     = '0;
    dec_found  = 1'b0;
    dec_n      = '0;
    resp_ready = 1'b0;

    // Reset dominates a pending request.
    tick();
    tick();
    req0_valid = 1'b1;
    req0_w     = 34'd9;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    tick();
    req0_valid = 1'b0;
    rst        = 1'b0;
    #1;
    chk_reset_outputs("reset");

    // Single request on req0.
    req0_valid = 1'b1;
    req0_w     = 34'd5;
    #1;
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("single_dec_w", dec_w, 34'd5);
    chk("single_busy", busy, 1);
    chk("single_req0_ready_c1", req0_ready, 0);
    tick();
    tick();
    tick();
    dec_found = 1'b1;
    dec_n     = 21'd1048575;
    #1;
    chk("single_resp_early", resp_valid, 0);
    tick();
    chk("single_resp_valid_c5", resp_valid, 1);
    chk("single_resp_id", resp_id, 0);
    chk("single_resp_n", resp_n, 21'd1048575);
    chk("single_resp_timeout", resp_timeout, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("single_idle_busy", busy, 0);
    chk("single_idle_resp_valid", resp_valid, 0);

    // Stale found from the previous word held into the new BLANK window.
    req1_valid = 1'b1;
    req1_w     = 34'd7;
    #1;
    chk("stale_req1_ready", req1_ready, 1);
    chk("stale_req0_ready", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("stale_dec_w", dec_w, 34'd7);
    tick();
    dec_found = 1'b0;
    tick();
    chk("stale_not_captured", resp_valid, 0);
    chk("stale_busy", busy, 1);
    tick();
    dec_found = 1'b1;
    dec_n     = 21'h00ABC;
    #1;
    chk("stale_resp_early", resp_valid, 0);
    tick();
    dec_found = 1'b0;
    chk("stale_resp_valid", resp_valid, 1);
    chk("stale_resp_id", resp_id, 1);
    chk("stale_resp_n", resp_n, 21'h00ABC);
    chk("stale_resp_timeout", resp_timeout, 0);

    // Backpressure with both requesters waiting.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_w     = W0;
    req1_w     = W1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_id", resp_id, 1);
      chk("bp_resp_n", resp_n, 21'h00ABC);
      chk("bp_resp_timeout", resp_timeout, 0);
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready", req1_ready, 0);
      chk("bp_busy", busy, 1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_accept_valid", resp_valid, 1);
    tick();
    resp_ready = 1'b0;
    #1;
    chk("bp_after_busy", busy, 0);
    chk("bp_after_resp_valid", resp_valid, 0);

    // Continuous load on both requesters: strict alternation.
    run_txn(1'b0, W0, 34'd7, 21'h11111, 1'b0);
    run_txn(1'b1, W1, W0, 21'h02222, 1'b0);
    run_txn(1'b0, W0, W1, 21'h13333, 1'b0);
    run_txn(1'b1, W1, W0, 21'h04444, 1'b1);

    // Timeout with found never asserted.
    req0_valid = 1'b1;
    req0_w     = 34'h3FF;
    #1;
    chk("to_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick();
    end
    chk("to_resp_early", resp_valid, 0);
    tick();
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_timeout", resp_timeout, 1);
    chk("to_resp_n", resp_n, 0);
    chk("to_resp_id", resp_id, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset while in WAIT, with found arriving in the reset cycle.
    req1_valid = 1'b1;
    req1_w     = 34'h123;
    #1;
    chk("rw_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    rst       = 1'b1;
    dec_found = 1'b1;
    dec_n     = 21'h5;
    tick();
    rst       = 1'b0;
    dec_found = 1'b0;
    chk_reset_outputs("rw");
    tick();
    chk("rw_no_resp", resp_valid, 0);

    // After reset the pointer favours req0, but only req1 is asking.
    req1_valid = 1'b1;
    req1_w     = 34'h0F0F;
    run_txn(1'b1, 34'h0F0F, 34'd0, 21'h01234, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_lut_scheduler.md
# dec_lut_scheduler

Two-requester round-robin scheduler that shares one DEC_LUT_Decoder20bits_clk instance. It accepts 34-bit codewords W from two clients over valid/ready handshakes and holds the selected word stable on the decoder. It then waits for the decoder's `found` (masked by a blanking window, bounded by a timeout) and returns N, the requester ID and a timeout flag on a valid/ready response port. It sits between the request sources and the decoder and owns all decoder sequencing.

## Interface
- W_BITS, 34, codeword width
- N_BITS, 21, decoder result width
- BLANK_CYC, 2, cycles after a new W during which `dec_found` is ignored (stale found from the previous word); legal range 1..15
- TIMEOUT_CYC, 1024, maximum cycles spent in WAIT before a timeout response; legal range 1..65535
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_w / req1_w  in  W_BITS  codeword
- dec_w  out  W_BITS  registered codeword driven to decoder W
- dec_found  in  1  decoder found
- dec_n  in  N_BITS  decoder N
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that owns the response
- resp_n  out  N_BITS  captured N (0 on timeout)
- resp_timeout  out  1  decoder did not assert found within TIMEOUT_CYC
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BLANK, WAIT, RESP.
- IDLE: if any reqX_valid, grant one requester; priority goes to `rr_ptr`, otherwise to the other valid requester. `reqX_ready` is combinational: it is 1 only in IDLE, only for the granted requester.
- On a grant: register `dec_w` <= granted word, `id` <= grantee, `rr_ptr` <= ~grantee, `cnt` <= 0; go to BLANK.
- BLANK: `cnt` increments each cycle and `dec_found` is ignored. When `cnt` == BLANK_CYC-1, reset `cnt` to 0 and go to WAIT.
- WAIT, `dec_found`==1 sampled: capture `resp_n` <= `dec_n`, `resp_timeout` <= 0; go to RESP.
- WAIT, otherwise: when `cnt` == TIMEOUT_CYC-1, set `resp_n` <= 0, `resp_timeout` <= 1 and go to RESP; else `cnt`++.
- RESP: `resp_valid`=1 with `resp_id`/`resp_n`/`resp_timeout` stable until `resp_ready`. On `resp_ready`, go to IDLE. There is no bypass: IDLE grants at the earliest on the cycle after the response handshake.
- `dec_w` holds its last value outside BLANK/WAIT and changes only on a grant.
- `cnt` width is clog2(max(BLANK_CYC, TIMEOUT_CYC))+1; it never wraps.
- Found and timeout in the same WAIT cycle: found wins (`resp_timeout`=0).
- Simultaneous valid on both requesters: `rr_ptr` wins, then the pointer flips, so strict alternation holds under continuous load.
- A requester deasserting valid while not granted is legal; no request is lost or duplicated.

## Timing
- Reset values: state IDLE, `dec_w`=0, `rr_ptr`=0 (req0 first), `cnt`=0, `resp_valid`=0, `resp_id`=0, `resp_n`=0, `resp_timeout`=0, `busy`=0, both `reqX_ready`=0.
- Reset mid-operation: the in-flight request is abandoned and no response is issued. Reset dominates all other inputs in the same cycle.
- Cycle numbering, with the grant at cycle 0:
  - `dec_w` is valid from cycle 1.
  - BLANK occupies cycles 1..BLANK_CYC.
  - `dec_found` is first sampled in cycle BLANK_CYC+1.
  - `resp_valid` rises in the cycle after `dec_found` is sampled high.
- Minimum latency, grant to `resp_valid`: BLANK_CYC+2 cycles (4 at default).
- Timeout latency, grant to `resp_valid`: BLANK_CYC+TIMEOUT_CYC+1 cycles.
- Throughput: one request per (latency + response handshake + 1) cycles.

## Test plan
- Single request: req0_w=34'd5, decoder model asserts found 3 cycles after W changes with N=21'd1048575 -> req0_ready pulses at cycle 0; resp_valid=1 with resp_id=0, resp_n=1048575, resp_timeout=0; resp_valid at cycle 5.
- Both requesters held valid for 4 requests -> grants in order 0,1,0,1; each resp_id matches its grantee; dec_w changes only on grants.
- Stale found: dec_found held at 1 from the previous word and dropped 1 cycle after the new W -> not captured during BLANK; response carries the N of the new word.
- Timeout: TIMEOUT_CYC=8, found never asserted -> resp_valid at cycle BLANK_CYC+9 with resp_timeout=1, resp_n=0.
- Backpressure: resp_ready held 0 for 10 cycles -> resp fields stable, both reqX_ready stay 0, busy=1; accepted on the first cycle resp_ready=1; IDLE the cycle after.
- Reset in WAIT: rst=1 for 1 cycle -> next cycle all outputs at reset values, no resp_valid; a following req1 request is granted (rr_ptr=0 but req0 is idle).
